// File: rtl/parity_tx_pkg.sv
// Shared types, constants and the parity helper for the parity serial transmitter.
package parity_tx_pkg;

   // Frame sequencer states, in transmission order.
   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } tx_state_t;

   localparam int   DATA_BITS   = 8;
   localparam int   FRAME_BITS  = 11;
   localparam logic IDLE_LEVEL  = 1'b1;
   localparam logic START_LEVEL = 1'b0;
   localparam logic STOP_LEVEL  = 1'b1;

   // Even parity is the XOR of the data bits; odd parity inverts it.
   function automatic logic parity_bit(input logic [DATA_BITS-1:0] data,
                                       input logic                 odd);
      return (^data) ^ odd;
   endfunction

endpackage

// File: rtl/parity_tx_scheduler_tx_bit_timer.sv
// Baud counter: counts 0..CLKS_PER_BIT-1 while run is high and flags the
// last clock of every bit period. Held at zero while run is low.
module tx_bit_timer #(
   parameter int CLKS_PER_BIT = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic run,
   output logic bit_done
);

   // 16 bits covers the full legal CLKS_PER_BIT range of 1..65535.
   localparam logic [15:0] LAST_COUNT = 16'(CLKS_PER_BIT - 1);

   logic [15:0] baud_cnt_reg;

   // Free-running count within a bit, wrapping on each bit boundary.
   always_ff @(posedge clk) begin
      if (rst || !run) begin
         baud_cnt_reg <= '0;
      end else if (baud_cnt_reg == LAST_COUNT) begin
         baud_cnt_reg <= '0;
      end else begin
         baud_cnt_reg <= baud_cnt_reg + 16'd1;
      end
   end

   // With CLKS_PER_BIT = 1 the count stays at zero and every running clock ends a bit.
   assign bit_done = run && (baud_cnt_reg == LAST_COUNT);

endmodule

// File: rtl/parity_tx_scheduler.sv
// Two-requester round-robin front end for a single parity UART-style
// transmitter: accepts one byte per frame and serialises
// start | 8 data (LSB first) | parity | stop, each CLKS_PER_BIT clocks long.
module parity_tx_scheduler
   import parity_tx_pkg::*;
#(
   parameter int   CLKS_PER_BIT = 4,
   parameter logic PARITY_ODD   = 1'b0
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] req_valid,
   input  logic [7:0] req_data0,
   input  logic [7:0] req_data1,
   output logic [1:0] req_ready,
   output logic       serial_out,
   output logic       busy,
   output logic       grant_id
);

   tx_state_t              state_reg;
   logic [DATA_BITS-1:0]   data_reg;
   logic [2:0]             bit_cnt_reg;
   logic                   last_reg;
   logic                   grant_reg;
   logic                   serial_reg;
   logic                   busy_reg;

   logic                   winner;
   logic                   any_valid;
   logic                   accept;
   logic [DATA_BITS-1:0]   winner_data;
   logic                   bit_done;
   logic                   timer_run;

   // Round-robin pick: a lone requester wins outright, a tie goes to the one not served last.
   always_comb begin
      winner    = 1'b0;
      any_valid = |req_valid;
      if (req_valid[0] && req_valid[1]) begin
         winner = ~last_reg;
      end else if (req_valid[1]) begin
         winner = 1'b1;
      end
      winner_data = winner ? req_data1 : req_data0;
   end

   // Ready is offered only in IDLE, only to the winner, and never while reset is asserted.
   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_ready
         assign req_ready[gi] = (state_reg == IDLE) && !rst && any_valid && (winner == 1'(gi));
      end
   endgenerate

   assign accept    = |(req_valid & req_ready);
   assign timer_run = (state_reg != IDLE);

   tx_bit_timer #(
      .CLKS_PER_BIT (CLKS_PER_BIT)
   ) u_bit_timer (
      .clk      (clk),
      .rst      (rst),
      .run      (timer_run),
      .bit_done (bit_done)
   );

   // Frame sequencer; serial_out is loaded with the level of the state being entered.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg   <= IDLE;
         data_reg    <= '0;
         bit_cnt_reg <= '0;
         last_reg    <= 1'b1;
         grant_reg   <= 1'b0;
         serial_reg  <= IDLE_LEVEL;
         busy_reg    <= 1'b0;
      end else begin
         case (state_reg)
            IDLE: begin
               serial_reg <= IDLE_LEVEL;
               if (accept) begin
                  data_reg   <= winner_data;
                  grant_reg  <= winner;
                  last_reg   <= winner;
                  state_reg  <= START;
                  serial_reg <= START_LEVEL;
                  busy_reg   <= 1'b1;
               end
            end
            START: begin
               if (bit_done) begin
                  state_reg   <= DATA;
                  bit_cnt_reg <= '0;
                  serial_reg  <= data_reg[0];
               end
            end
            DATA: begin
               if (bit_done) begin
                  if (bit_cnt_reg == 3'(DATA_BITS - 1)) begin
                     state_reg  <= PARITY;
                     serial_reg <= parity_bit(data_reg, PARITY_ODD);
                  end else begin
                     bit_cnt_reg <= bit_cnt_reg + 3'd1;
                     serial_reg  <= data_reg[bit_cnt_reg + 3'd1];
                  end
               end
            end
            PARITY: begin
               if (bit_done) begin
                  state_reg  <= STOP;
                  serial_reg <= STOP_LEVEL;
               end
            end
            STOP: begin
               if (bit_done) begin
                  state_reg  <= IDLE;
                  serial_reg <= IDLE_LEVEL;
                  busy_reg   <= 1'b0;
               end
            end
            default: begin
               state_reg  <= IDLE;
               serial_reg <= IDLE_LEVEL;
               busy_reg   <= 1'b0;
            end
         endcase
      end
   end

   assign serial_out = serial_reg;
   assign busy       = busy_reg;
   assign grant_id   = grant_reg;

endmodule

// File: tb/tb_parity_tx_scheduler.sv
// Directed bench: main instance (4 clk/bit, even), a twin with odd parity
// sharing its inputs, and a 1 clk/bit instance with its own requesters.
module tb_parity_tx_scheduler;

   logic       clk = 1'b0;
   logic       rst;
   logic [1:0] valid_m;
   logic [7:0] d0_m, d1_m;
   logic [1:0] ready_m, ready_o, ready_f;
   logic       ser_m, ser_o, ser_f;
   logic       busy_m, busy_o, busy_f;
   logic       gid_m, gid_o, gid_f;
   logic [1:0] valid_f;
   logic [7:0] d0_f, d1_f;

   int n_assert = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   parity_tx_scheduler #(.CLKS_PER_BIT(4), .PARITY_ODD(1'b0)) dut (
      .clk(clk), .rst(rst), .req_valid(valid_m), .req_data0(d0_m), .req_data1(d1_m),
      .req_ready(ready_m), .serial_out(ser_m), .busy(busy_m), .grant_id(gid_m));

   parity_tx_scheduler #(.CLKS_PER_BIT(4), .PARITY_ODD(1'b1)) dut_odd (
      .clk(clk), .rst(rst), .req_valid(valid_m), .req_data0(d0_m), .req_data1(d1_m),
      .req_ready(ready_o), .serial_out(ser_o), .busy(busy_o), .grant_id(gid_o));

   parity_tx_scheduler #(.CLKS_PER_BIT(1), .PARITY_ODD(1'b0)) dut_fast (
      .clk(clk), .rst(rst), .req_valid(valid_f), .req_data0(d0_f), .req_data1(d1_f),
      .req_ready(ready_f), .serial_out(ser_f), .busy(busy_f), .grant_id(gid_f));

   task automatic chk1(input string tag, input logic obs, input logic exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic chk2(input string tag, input logic [1:0] obs, input logic [1:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   // Check the first nslots bit slots of a 4-clock-per-bit frame on both 4-clk instances.
   task automatic check_frame(input string tag, input logic [7:0] b, input logic par_e,
                              input logic par_o, input logic gid, input int nslots);
      logic exp_e, exp_o;
      for (int slot = 0; slot < nslots; slot++) begin
         if (slot == 0) begin
            exp_e = 1'b0; exp_o = 1'b0;
         end else if (slot <= 8) begin
            exp_e = b[slot-1]; exp_o = b[slot-1];
         end else if (slot == 9) begin
            exp_e = par_e; exp_o = par_o;
         end else begin
            exp_e = 1'b1; exp_o = 1'b1;
         end
         for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk1($sformatf("%s_ser_slot%0d", tag, slot), ser_m, exp_e);
            chk1($sformatf("%s_odd_ser_slot%0d", tag, slot), ser_o, exp_o);
            chk1($sformatf("%s_busy_slot%0d", tag, slot), busy_m, 1'b1);
            if (c == 0) begin
               chk1($sformatf("%s_grant_slot%0d", tag, slot), gid_m, gid);
               chk1($sformatf("%s_odd_busy_slot%0d", tag, slot), busy_o, 1'b1);
               chk2($sformatf("%s_ready_slot%0d", tag, slot), ready_m, 2'b00);
            end
         end
      end
      $display("frame %s byte=%02h grant=%0d slots=%0d checked", tag, b, gid, nslots);
   endtask

   task automatic check_idle(input string tag);
      @(negedge clk);
      chk1({tag, "_idle_ser"}, ser_m, 1'b1);
      chk1({tag, "_idle_busy"}, busy_m, 1'b0);
   endtask

   initial begin
      // Reset hold with both requesters valid (they also set up the contention case).
      rst = 1'b1; valid_m = 2'b11; d0_m = 8'd45; d1_m = 8'd101;
      valid_f = 2'b00; d0_f = 8'h00; d1_f = 8'h00;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk1("rst_ser", ser_m, 1'b1);
         chk2("rst_ready", ready_m, 2'b00);
         chk1("rst_busy", busy_m, 1'b0);
         chk1("rst_grant", gid_m, 1'b0);
         chk2("rst_ready_odd", ready_o, 2'b00);
      end
      $display("reset hold: 3 cycles checked");

      // Contention: requester 0 first, then requester 1 after a single IDLE cycle.
      rst = 1'b0;
      #1 chk2("cont_ready0", ready_m, 2'b01);
      @(posedge clk); #1 valid_m = 2'b10;
      check_frame("cont0", 8'd45, 1'b0, 1'b1, 1'b0, 11);
      @(negedge clk);
      chk1("cont_gap_ser", ser_m, 1'b1);
      chk1("cont_gap_busy", busy_m, 1'b0);
      chk2("cont_gap_ready", ready_m, 2'b10);
      @(posedge clk); #1 valid_m = 2'b00;
      check_frame("cont1", 8'd101, 1'b0, 1'b1, 1'b1, 11);
      check_idle("cont1");

      // A valid pulse that never meets a clock edge must not start a frame.
      valid_m = 2'b01; d0_m = 8'h77;
      #2 valid_m = 2'b00;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk1("drop_busy", busy_m, 1'b0);
         chk1("drop_ser", ser_m, 1'b1);
      end
      $display("dropped valid: no frame");

      // Single byte 0x0C from requester 0.
      valid_m = 2'b01; d0_m = 8'h0C;
      #1 chk2("single_ready", ready_m, 2'b01);
      @(posedge clk); #1 valid_m = 2'b00;
      check_frame("single", 8'h0C, 1'b0, 1'b1, 1'b0, 11);
      check_idle("single");

      // Byte 0x43: even parity 1, odd parity 0.
      valid_m = 2'b10; d1_m = 8'h43;
      #1 chk2("par_ready", ready_m, 2'b10);
      @(posedge clk); #1 valid_m = 2'b00;
      check_frame("par", 8'h43, 1'b1, 1'b0, 1'b1, 11);
      check_idle("par");

      // Reset during DATA bit 3 of byte 9, then a fresh byte right after.
      valid_m = 2'b01; d0_m = 8'd9;
      #1 chk2("mid_ready", ready_m, 2'b01);
      @(posedge clk); #1 valid_m = 2'b00;
      check_frame("mid", 8'd9, 1'b0, 1'b1, 1'b0, 4);
      @(negedge clk);
      chk1("mid_bit3", ser_m, 1'b1);
      chk1("mid_bit3_busy", busy_m, 1'b1);
      rst = 1'b1;
      @(negedge clk);
      chk1("mid_rst_ser", ser_m, 1'b1);
      chk1("mid_rst_busy", busy_m, 1'b0);
      chk1("mid_rst_grant", gid_m, 1'b0);
      rst = 1'b0; valid_m = 2'b01; d0_m = 8'hA5;
      #1 chk2("after_rst_ready", ready_m, 2'b01);
      @(posedge clk); #1 valid_m = 2'b00;
      check_frame("after_rst", 8'hA5, 1'b0, 1'b1, 1'b0, 11);
      check_idle("after_rst");

      // One clock per bit: byte 0xFF gives 0, 1 x8, 0, 1.
      @(negedge clk);
      valid_f = 2'b01; d0_f = 8'hFF;
      #1 chk2("fast_ready", ready_f, 2'b01);
      @(posedge clk); #1 valid_f = 2'b00;
      for (int slot = 0; slot < 11; slot++) begin
         @(negedge clk);
         chk1($sformatf("fast_ser_slot%0d", slot), ser_f,
              (slot == 0 || slot == 9) ? 1'b0 : 1'b1);
         chk1($sformatf("fast_busy_slot%0d", slot), busy_f, 1'b1);
      end
      @(negedge clk);
      chk1("fast_idle_ser", ser_f, 1'b1);
      chk1("fast_idle_busy", busy_f, 1'b0);
      $display("fast frame byte=ff checked");

      // Both requesters held valid: grants alternate, starting with 1 (0 was served last).
      valid_f = 2'b11; d0_f = 8'h00; d1_f = 8'h01;
      #1 chk2("alt_ready0", ready_f, 2'b10);
      for (int f = 0; f < 3; f++) begin
         @(negedge clk);
         chk1($sformatf("alt_grant%0d", f), gid_f, (f % 2 == 0) ? 1'b1 : 1'b0);
         chk1($sformatf("alt_busy%0d", f), busy_f, 1'b1);
         repeat (10) @(negedge clk);
         @(negedge clk);
         chk1($sformatf("alt_gap_busy%0d", f), busy_f, 1'b0);
         chk2($sformatf("alt_gap_ready%0d", f), ready_f, (f % 2 == 0) ? 2'b01 : 2'b10);
         $display("alternation frame %0d checked", f);
      end
      valid_f = 2'b00;
      @(negedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
